// File: rtl/apb_completer_regbank.sv
// apb_completer_regbank: APB4 completer with a small word-addressed register bank.
//   Words 0..NUM_REGS-2 are read/write with byte strobes; word NUM_REGS-1 is a read-only
//   status word taken from status_i. Every transfer inserts WAIT_CYCLES wait states.
//   Optional feature macro: APB_SLVERR_EN (error response for out-of-range / RO writes).
// Ports:
//   pclk, preset          clock, synchronous active-high reset
//   psel, penable, pwrite APB control
//   paddr, pwdata, pstrb  APB address / write data / byte enables
//   prdata, pready,       APB response (registered)
//   pslverr
//   status_i              value returned for the read-only word
//   regs_o                RW words flattened, word k at [k*DATA_W +: DATA_W]; RO slot reads 0
module apb_completer_regbank #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NUM_REGS    = 4,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] RST_VAL     = '0
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  input  logic [3:0]                   pstrb,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  input  logic [DATA_W-1:0]            status_i,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

  localparam int unsigned    IDX_W  = ADDR_W - 2;
  localparam int unsigned    CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] RO_IDX = IDX_W'(NUM_REGS - 1);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACCESS = 1'b1;

  logic              r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_strb;
  logic              r_pready;
  logic [DATA_W-1:0] r_prdata;
  logic              r_pslverr;
  logic [DATA_W-1:0] r_regs [NUM_REGS-1];

  logic              w_setup;
  logic [IDX_W-1:0]  w_cur_idx;
  logic              w_cur_wr;
  logic              w_oor;
  logic              w_ro;
  logic              w_err;
  logic              w_complete_next;
  logic              w_commit;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  // Byte offset bits carry no meaning in a word-addressed map.
  assign w_unused = ^paddr[1:0];

  assign w_setup = (r_state == ST_IDLE) && psel && !penable;

  // The response is registered on the edge that raises pready, which for zero-wait
  // transfers is the setup edge itself, so decode from the live bus while idle.
  assign w_cur_idx = (r_state == ST_IDLE) ? paddr[ADDR_W-1:2] : r_idx;
  assign w_cur_wr  = (r_state == ST_IDLE) ? pwrite : r_write;
  assign w_oor     = 32'(w_cur_idx) >= NUM_REGS;
  assign w_ro      = (w_cur_idx == RO_IDX);

`ifdef APB_SLVERR_EN
  assign w_err = w_oor || (w_cur_wr && w_ro);
`else
  assign w_err = 1'b0;
`endif

  assign w_complete_next = w_setup ? (WAIT_CYCLES == 0)
                         : ((r_state == ST_ACCESS) && !r_pready && psel
                            && (r_cnt == CNT_W'(1)));

  assign w_commit = (r_state == ST_ACCESS) && r_pready && r_write && !w_oor && !w_ro;

  always_comb begin
    w_rdata = '0;
    if (!w_cur_wr && !w_oor && !w_err) begin
      if (w_ro) begin
        w_rdata = status_i;
      end else begin
        for (int k = 0; k < NUM_REGS - 1; k++) begin
          if (w_cur_idx == IDX_W'(k)) w_rdata = r_regs[k];
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
      if (w_complete_next) begin
        r_pready  <= 1'b1;
        r_prdata  <= w_rdata;
        r_pslverr <= w_err;
      end
      case (r_state)
        ST_IDLE: begin
          // psel & penable while idle is a protocol error and is ignored.
          if (w_setup) begin
            r_state <= ST_ACCESS;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
            r_write <= pwrite;
            r_idx   <= paddr[ADDR_W-1:2];
            r_wdata <= pwdata;
            r_strb  <= pstrb;
          end
        end
        default: begin
          if (r_pready || !psel) begin
            // Completion, or requester abandoned the transfer before pready.
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int k = 0; k < NUM_REGS - 1; k++) r_regs[k] <= RST_VAL;
    end else if (w_commit) begin
      for (int k = 0; k < NUM_REGS - 1; k++) begin
        if (r_idx == IDX_W'(k)) begin
          for (int b = 0; b < 4; b++) begin
            if (r_strb[b]) r_regs[k][8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS - 1; k++) regs_o[k*DATA_W +: DATA_W] = r_regs[k];
  end

  assign pready  = r_pready;
  assign prdata  = r_prdata;
  assign pslverr = r_pslverr;

endmodule
